// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared encodings for the RV32I multicycle main control unit:
//               FSM states, opcode constants, instruction classes and
//               datapath select codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

  // FSM state encodings, also exported on the State debug port
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  // Supported RV32I major opcodes
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Instruction class latched in DECODE
  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I_ALU   = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_JAL     = 3'd5,
    CLS_ILLEGAL = 3'd6
  } class_e;

  // ALUOp codes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Write-back source select
  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC4    = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // Classes that need a data-memory access after EXEC
  function automatic logic is_mem_class(input class_e cls);
    return (cls == CLS_LOAD) || (cls == CLS_STORE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/opcode_classifier.sv
// ============================================================================
// Module      : opcode_classifier
// Description : Combinational decode of the instruction-register opcode field
//               into an instruction class; anything unsupported is ILLEGAL.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module opcode_classifier
  import ctrl_pkg::*;
#(
  parameter int OP_WIDTH = 7
) (
  input  logic [OP_WIDTH-1:0] opcode_i,
  output logic [2:0]          class_o
);

  // Map each supported major opcode to its class, default to ILLEGAL
  always_comb begin
    class_o = CLS_ILLEGAL;
    if (opcode_i == OP_WIDTH'(OPC_R))           class_o = CLS_R;
    else if (opcode_i == OP_WIDTH'(OPC_I_ALU))  class_o = CLS_I_ALU;
    else if (opcode_i == OP_WIDTH'(OPC_LOAD))   class_o = CLS_LOAD;
    else if (opcode_i == OP_WIDTH'(OPC_STORE))  class_o = CLS_STORE;
    else if (opcode_i == OP_WIDTH'(OPC_BRANCH)) class_o = CLS_BRANCH;
    else if (opcode_i == OP_WIDTH'(OPC_JAL))    class_o = CLS_JAL;
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multicycle main control FSM for the RV32I core. Steps each
//               instruction through FETCH/DECODE/EXEC/MEM/WB, drives datapath
//               selects and enables, handshakes with a variable-latency
//               unified memory and times out stalled accesses.
// Config      : ILLEGAL_TRAP_EN - when defined, unsupported opcodes park the
//               FSM in TRAP with IllegalInst high; otherwise they retire as
//               NOPs from DECODE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OP_WIDTH     = 7,
  parameter int ALUOP_WIDTH  = 2,
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [OP_WIDTH-1:0]    Opcode,
  input  logic                   MemReady,
  output logic                   PCWrite,
  output logic                   IRWrite,
  output logic                   Branch,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IorD,
  output logic [1:0]             MemtoReg,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [ALUOP_WIDTH-1:0] ALUOp,
  output logic                   RegWrite,
  output logic                   InstRetire,
  output logic                   MemFault,
  output logic                   IllegalInst,
  output logic [2:0]             State
);

  localparam int             CNT_W    = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

  state_e            state_q, state_d;
  class_e            class_q, class_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [2:0]        w_cls_raw;
  class_e            w_cls;
  logic              w_waiting;
  logic              w_timeout;

  opcode_classifier #(
    .OP_WIDTH (OP_WIDTH)
  ) u_opcode_classifier (
    .opcode_i (Opcode),
    .class_o  (w_cls_raw)
  );

  assign w_cls = class_e'(w_cls_raw);

  // A stalled access times out when the last allowed wait cycle also misses MemReady
  assign w_waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign w_timeout = w_waiting && !MemReady && (cnt_q == CNT_LAST);

  // Next-state, class latch and wait-counter logic
  always_comb begin
    state_d = state_q;
    class_d = class_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH: begin
        // A fetch timeout stays in FETCH so the same PC is retried
        if (MemReady) state_d = ST_DECODE;
        else          state_d = ST_FETCH;
      end
      ST_DECODE: begin
        class_d = w_cls;
        if (w_cls == CLS_ILLEGAL) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = ST_TRAP;
`else
          state_d = ST_FETCH;
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_mem_class(class_q))      state_d = ST_MEM;
        else if (class_q == CLS_BRANCH) state_d = ST_FETCH;
        else if (class_q == CLS_ILLEGAL) state_d = ST_FETCH;
        else                            state_d = ST_WB;
      end
      ST_MEM: begin
        if (MemReady) begin
          state_d = (class_q == CLS_LOAD) ? ST_WB : ST_FETCH;
        end else if (w_timeout) begin
          // Abandon the instruction: no write-back, no retire
          state_d = ST_FETCH;
        end
      end
      ST_WB:     state_d = ST_FETCH;
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_IDLE;
    endcase

    // Counter only advances while an access is still pending in place;
    // every entry into FETCH/MEM (including a timeout retry) restarts it
    if (w_waiting && !MemReady && !w_timeout) cnt_d = cnt_q + CNT_W'(1);
    else                                      cnt_d = '0;
  end

  // State, class and wait-counter registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      class_q <= CLS_R;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore control decode from state and class, with MemReady qualification
  always_comb begin
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    Branch      = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    MemtoReg    = MTR_ALUOUT;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RS2;
    ALUOp       = ALUOP_WIDTH'(ALUOP_ADD);
    RegWrite    = 1'b0;
    InstRetire  = 1'b0;
    IllegalInst = 1'b0;
    case (state_q)
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        ALUOp   = ALUOP_WIDTH'(ALUOP_ADD);
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      ST_DECODE: begin
`ifndef ILLEGAL_TRAP_EN
        // The class register is not yet loaded here, so the NOP retire
        // comes straight from the classifier on the registered IR opcode
        InstRetire = (w_cls == CLS_ILLEGAL);
`endif
      end
      ST_EXEC: begin
        case (class_q)
          CLS_R: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_RS2;
            ALUOp   = ALUOP_WIDTH'(ALUOP_FUNCT);
          end
          CLS_I_ALU: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_WIDTH'(ALUOP_FUNCT);
          end
          CLS_LOAD, CLS_STORE: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_WIDTH'(ALUOP_ADD);
          end
          CLS_BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = SRCB_RS2;
            ALUOp      = ALUOP_WIDTH'(ALUOP_SUB);
            Branch     = 1'b1;
            InstRetire = 1'b1;
          end
          CLS_JAL: begin
            ALUSrcA = 1'b0;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_WIDTH'(ALUOP_ADD);
            PCWrite = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        IorD       = 1'b1;
        MemRead    = (class_q == CLS_LOAD);
        MemWrite   = (class_q == CLS_STORE);
        InstRetire = MemReady && (class_q == CLS_STORE);
      end
      ST_WB: begin
        RegWrite   = 1'b1;
        InstRetire = 1'b1;
        if (class_q == CLS_LOAD)     MemtoReg = MTR_MDR;
        else if (class_q == CLS_JAL) MemtoReg = MTR_PC4;
        else                         MemtoReg = MTR_ALUOUT;
      end
      ST_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        IllegalInst = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  assign MemFault = w_timeout;
  assign State    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl: a cycle-by-cycle
//               vector table for the normal instruction flows plus directed
//               sequences for timeouts, reset mid-access and illegal opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EX = 3'd3,
                         S_MEM  = 3'd4, S_WB    = 3'd5, S_TRAP = 3'd6;

  localparam logic [6:0] OP_R  = 7'b0110011, OP_I  = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_J  = 7'b1101111,
                         OP_BAD = 7'b1111111;

  logic       Clk, Rst_n, MemReady;
  logic [6:0] Opcode;
  logic       PCWrite, IRWrite, Branch, MemRead, MemWrite, IorD;
  logic [1:0] MemtoReg, ALUSrcB, ALUOp;
  logic       ALUSrcA, RegWrite, InstRetire, MemFault, IllegalInst;
  logic [2:0] State;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_ctrl #(
    .OP_WIDTH     (7),
    .ALUOP_WIDTH  (2),
    .MEM_WAIT_MAX (16)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Opcode      (Opcode),
    .MemReady    (MemReady),
    .PCWrite     (PCWrite),
    .IRWrite     (IRWrite),
    .Branch      (Branch),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IorD        (IorD),
    .MemtoReg    (MemtoReg),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .RegWrite    (RegWrite),
    .InstRetire  (InstRetire),
    .MemFault    (MemFault),
    .IllegalInst (IllegalInst),
    .State       (State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Packed control word: {PCWrite,IRWrite,Branch,MemRead,MemWrite,IorD,
  //  MemtoReg,ALUSrcA,ALUSrcB,ALUOp,RegWrite,InstRetire,MemFault,IllegalInst}
  function automatic logic [16:0] mk(input logic pcw, input logic irw, input logic br,
                                     input logic mr, input logic mw, input logic iord,
                                     input logic [1:0] mtr, input logic asa,
                                     input logic [1:0] asb, input logic [1:0] aop,
                                     input logic rw, input logic ir, input logic mf,
                                     input logic ill);
    return {pcw, irw, br, mr, mw, iord, mtr, asa, asb, aop, rw, ir, mf, ill};
  endfunction

  function automatic logic [16:0] actual();
    return {PCWrite, IRWrite, Branch, MemRead, MemWrite, IorD, MemtoReg, ALUSrcA,
            ALUSrcB, ALUOp, RegWrite, InstRetire, MemFault, IllegalInst};
  endfunction

  typedef struct {
    logic        mr;
    logic [6:0]  op;
    logic [2:0]  st;
    logic [16:0] ex;
  } vec_t;

  vec_t vecs[40];
  int   nv = 0;

  logic [16:0] Z, FW, FR, FT, DI, XR, XI, XLS, XB, XJ, ML, MS, MSR, MST, WA, WL, WJ, TR;

  task automatic add(input logic mr, input logic [6:0] op, input logic [2:0] st,
                     input logic [16:0] ex);
    vecs[nv] = '{mr, op, st, ex};
    nv++;
  endtask

  task automatic drive(input logic mr, input logic [6:0] op);
    MemReady = mr;
    Opcode   = op;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic chk(input string nm, input logic [2:0] st, input logic [16:0] ex);
    n_tests++;
    if (State !== st) begin
      n_fail++;
      $display("FAIL %s state: got %0d want %0d", nm, State, st);
    end
    n_tests++;
    if (actual() !== ex) begin
      n_fail++;
      $display("FAIL %s ctrl: got %b want %b", nm, actual(), ex);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int rw_seen;

  initial begin
    Z   = '0;
    FW  = mk(0,0,0,1,0,0,2'b00,0,2'b01,2'b00,0,0,0,0);
    FR  = mk(1,1,0,1,0,0,2'b00,0,2'b01,2'b00,0,0,0,0);
    FT  = mk(0,0,0,1,0,0,2'b00,0,2'b01,2'b00,0,0,1,0);
    DI  = mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,1,0,0);
    XR  = mk(0,0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0,0,0);
    XI  = mk(0,0,0,0,0,0,2'b00,1,2'b10,2'b10,0,0,0,0);
    XLS = mk(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0);
    XB  = mk(0,0,1,0,0,0,2'b00,1,2'b00,2'b01,0,1,0,0);
    XJ  = mk(1,0,0,0,0,0,2'b00,0,2'b10,2'b00,0,0,0,0);
    ML  = mk(0,0,0,1,0,1,2'b00,0,2'b00,2'b00,0,0,0,0);
    MS  = mk(0,0,0,0,1,1,2'b00,0,2'b00,2'b00,0,0,0,0);
    MSR = mk(0,0,0,0,1,1,2'b00,0,2'b00,2'b00,0,1,0,0);
    MST = mk(0,0,0,0,1,1,2'b00,0,2'b00,2'b00,0,0,1,0);
    WA  = mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,1,0,0);
    WL  = mk(0,0,0,0,0,0,2'b01,0,2'b00,2'b00,1,1,0,0);
    WJ  = mk(0,0,0,0,0,0,2'b10,0,2'b00,2'b00,1,1,0,0);
    TR  = mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,1);

    // R-type, zero-wait: IDLE, FETCH, DECODE, EXEC, WB
    add(1, OP_R, S_IDLE, Z);   add(1, OP_R, S_FETCH, FR); add(1, OP_R, S_DEC, Z);
    add(1, OP_R, S_EX, XR);    add(1, OP_R, S_WB, WA);
    // I-ALU
    add(1, OP_I, S_FETCH, FR); add(1, OP_I, S_DEC, Z);    add(1, OP_I, S_EX, XI);
    add(1, OP_I, S_WB, WA);
    // LOAD with three MEM wait cycles: 8 cycles total
    add(1, OP_LD, S_FETCH, FR); add(1, OP_LD, S_DEC, Z);  add(1, OP_LD, S_EX, XLS);
    add(0, OP_LD, S_MEM, ML);   add(0, OP_LD, S_MEM, ML); add(0, OP_LD, S_MEM, ML);
    add(1, OP_LD, S_MEM, ML);   add(1, OP_LD, S_WB, WL);
    // STORE zero-wait: retires in MEM
    add(1, OP_ST, S_FETCH, FR); add(1, OP_ST, S_DEC, Z);  add(1, OP_ST, S_EX, XLS);
    add(1, OP_ST, S_MEM, MSR);
    // BRANCH: 3 cycles, retires in EXEC
    add(1, OP_BR, S_FETCH, FR); add(1, OP_BR, S_DEC, Z);  add(1, OP_BR, S_EX, XB);
    // JAL
    add(1, OP_J, S_FETCH, FR);  add(1, OP_J, S_DEC, Z);   add(1, OP_J, S_EX, XJ);
    add(1, OP_J, S_WB, WJ);
    // Fetch with two wait cycles; MemReady low outside FETCH/MEM is ignored
    add(0, OP_R, S_FETCH, FW);  add(0, OP_R, S_FETCH, FW); add(1, OP_R, S_FETCH, FR);
    add(0, OP_R, S_DEC, Z);     add(0, OP_R, S_EX, XR);    add(0, OP_R, S_WB, WA);

    // Reset state, with MemReady high to show it is ignored in IDLE
    Rst_n = 1'b0;
    drive(0, 7'd0);
    @(negedge Clk);
    @(negedge Clk);
    drive(1, OP_R);
    chk("reset", S_IDLE, Z);
    Rst_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      drive(vecs[i].mr, vecs[i].op);
      chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].ex);
      tick();
    end

    // STORE with MemReady stuck low: fault in the 16th MEM cycle
    rw_seen = 0;
    drive(1, OP_ST); chk("st_to_fetch", S_FETCH, FR); tick();
    drive(0, OP_ST); chk("st_to_dec", S_DEC, Z);      tick();
    drive(0, OP_ST); chk("st_to_exec", S_EX, XLS);    tick();
    for (int k = 1; k <= 16; k++) begin
      drive(0, OP_ST);
      if (RegWrite) rw_seen++;
      if (k < 16) chk($sformatf("st_wait%0d", k), S_MEM, MS);
      else        chk("st_timeout", S_MEM, MST);
      tick();
    end
    n_tests++;
    if (rw_seen != 0) begin
      n_fail++;
      $display("FAIL st_no_regwrite: got %0d RegWrite cycles want 0", rw_seen);
    end

    // STORE whose MemReady lands exactly in the timeout cycle completes normally
    drive(1, OP_ST); chk("st2_fetch", S_FETCH, FR); tick();
    drive(1, OP_ST); chk("st2_dec", S_DEC, Z);      tick();
    drive(1, OP_ST); chk("st2_exec", S_EX, XLS);    tick();
    for (int k = 1; k <= 15; k++) begin
      drive(0, OP_ST);
      chk($sformatf("st2_wait%0d", k), S_MEM, MS);
      tick();
    end
    drive(1, OP_ST); chk("st2_late_ready", S_MEM, MSR); tick();

    // Fetch timeout: retry in FETCH with no PC update, counter restarted
    for (int k = 1; k <= 16; k++) begin
      drive(0, OP_LD);
      if (k < 16) chk($sformatf("f_wait%0d", k), S_FETCH, FW);
      else        chk("f_timeout", S_FETCH, FT);
      tick();
    end
    drive(0, OP_LD); chk("f_retry", S_FETCH, FW);   tick();
    drive(1, OP_LD); chk("ld_fetch", S_FETCH, FR);  tick();
    drive(0, OP_LD); chk("ld_dec", S_DEC, Z);       tick();
    drive(0, OP_LD); chk("ld_exec", S_EX, XLS);     tick();
    drive(0, OP_LD); chk("ld_wait1", S_MEM, ML);    tick();
    drive(0, OP_LD); chk("ld_wait2", S_MEM, ML);

    // Asynchronous reset in the middle of the MEM wait
    Rst_n = 1'b0;
    drive(1, OP_LD); chk("rst_async", S_IDLE, Z);   tick();
    drive(1, OP_LD); chk("rst_hold", S_IDLE, Z);
    Rst_n = 1'b1;
    drive(0, OP_LD); chk("rst_release", S_IDLE, Z); tick();
    drive(0, OP_LD); chk("rst_fetch", S_FETCH, FW); tick();

    // Unsupported opcode
    drive(1, OP_BAD); chk("bad_fetch", S_FETCH, FR); tick();
`ifdef ILLEGAL_TRAP_EN
    drive(1, OP_BAD); chk("bad_dec", S_DEC, Z); tick();
    for (int k = 0; k < 3; k++) begin
      drive(k[0], OP_R);
      chk($sformatf("trap%0d", k), S_TRAP, TR);
      tick();
    end
    Rst_n = 1'b0;
    drive(0, OP_R); chk("trap_reset", S_IDLE, Z);
    tick();
    Rst_n = 1'b1;
`else
    drive(1, OP_BAD); chk("bad_dec_nop", S_DEC, DI); tick();
    drive(0, OP_R);   chk("bad_next_fetch", S_FETCH, FW); tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
